// File: rtl/disp_mask_pkg.sv
// Shared types and constants for the display mask controller.
package disp_mask_pkg;

  // Mask sequencing mode as written to CTRL[1:0]
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

  // Per-frame sequencer states
  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ON      = 3'd1,
    S_BLK_ON  = 3'd2,
    S_BLK_OFF = 3'd3,
    S_PULSE   = 3'd4,
    S_PDONE   = 3'd5
  } state_t;

  // Slot register addresses (addr[2:0])
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_BORDER = 3'd2;
  localparam logic [2:0] ADDR_WIN    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // Reset values
  localparam logic [11:0] BORDER_RST = 12'hfff;
  localparam logic [7:0]  PERIOD_RST = 8'd1;

  // Terminal frame count for a period; a period of 0 behaves like 1
  function automatic logic [7:0] period_last(input logic [7:0] period);
    period_last = (period == 8'd0) ? 8'd0 : period - 8'd1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-start detector: one-clk pulse on the first cycle the pixel
// counter sits at (0,0), no matter how many clks each pixel lasts.
module frame_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        frame_tick
);

  logic zero;
  logic z_q;

  assign zero = (x == 11'd0) && (y == 11'd0);

  // Remember whether the previous cycle was already at (0,0); resetting to 1
  // suppresses a spurious tick when reset releases at the origin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q <= 1'b1;
    end else begin
      z_q <= zero;
    end
  end

  assign frame_tick = zero && !z_q;

endmodule

// File: rtl/disp_mask_ctrl.sv
// Display mask controller: double-buffered slot registers that commit at
// frame start, plus a per-frame sequencer driving the mask enable.
module disp_mask_ctrl
  import disp_mask_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        cs,
  input  logic        write,
  input  logic [13:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        mask_en,
  output logic [11:0] border_rgb,
  output logic [10:0] win_lo,
  output logic [10:0] win_hi,
  output logic        frame_tick
);

  localparam logic [10:0] WIN_HI_RST = 11'(H_ACTIVE - 1);

  logic [2:0]  sel;
  logic        wr_en;
  logic        wr_go;
  logic [7:0]  p_last;

  // Pending (software-visible) copies
  mode_t       mode_p_q;
  logic [7:0]  period_p_q;
  logic [11:0] border_p_q;
  logic [10:0] win_lo_p_q;
  logic [10:0] win_hi_p_q;

  // Committed copies driving the datapath
  logic [11:0] border_rgb_q;
  logic [10:0] win_lo_q;
  logic [10:0] win_hi_q;

  // Sequencer state
  state_t      state_q;
  logic [7:0]  fcnt_q;
  logic        go_pend_q;
  logic        done_q;
  logic        mask_en_q;

  logic        busy;
  logic        phase;
  logic        unused_bits;

  assign sel   = addr[2:0];
  assign wr_en = cs && write;
  assign wr_go = wr_en && (sel == ADDR_CTRL) && wr_data[2];

  // The sequencer uses the values being committed at the same tick
  assign p_last = period_last(period_p_q);

  assign busy  = (state_q == S_PULSE);
  assign phase = (state_q == S_BLK_ON);

  // Upper address bits and unmapped data bits are intentionally ignored
  assign unused_bits = ^{addr[13:3], wr_data[31:27], wr_data[15:12]};

  frame_tick_gen u_tick (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick)
  );

  // Slot writes land in the pending registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_p_q   <= MODE_OFF;
      period_p_q <= PERIOD_RST;
      border_p_q <= BORDER_RST;
      win_lo_p_q <= 11'd0;
      win_hi_p_q <= WIN_HI_RST;
    end else if (wr_en) begin
      case (sel)
        ADDR_CTRL:   mode_p_q   <= mode_t'(wr_data[1:0]);
        ADDR_PERIOD: period_p_q <= wr_data[7:0];
        ADDR_BORDER: border_p_q <= wr_data[11:0];
        ADDR_WIN: begin
          win_lo_p_q <= wr_data[10:0];
          win_hi_p_q <= wr_data[26:16];
        end
        default: ;
      endcase
    end
  end

  // Committed registers copy pending at frame start; a write in the tick
  // cycle is not yet in pending, so it waits for the following frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      border_rgb_q <= BORDER_RST;
      win_lo_q     <= 11'd0;
      win_hi_q     <= WIN_HI_RST;
    end else if (frame_tick) begin
      border_rgb_q <= border_p_q;
      win_lo_q     <= win_lo_p_q;
      win_hi_q     <= win_hi_p_q;
    end
  end

  // Per-frame sequencer with registered mask enable, go latch and done flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_OFF;
      fcnt_q    <= 8'd0;
      go_pend_q <= 1'b0;
      done_q    <= 1'b0;
      mask_en_q <= 1'b0;
    end else begin
      // A go in the tick cycle is kept for the next frame
      if (wr_go) begin
        go_pend_q <= 1'b1;
        done_q    <= 1'b0;
      end else if (frame_tick) begin
        go_pend_q <= 1'b0;
      end

      if (frame_tick) begin
        case (mode_p_q)
          MODE_OFF: begin
            state_q   <= S_OFF;
            fcnt_q    <= 8'd0;
            mask_en_q <= 1'b0;
          end
          MODE_ON: begin
            state_q   <= S_ON;
            fcnt_q    <= 8'd0;
            mask_en_q <= 1'b1;
          end
          MODE_BLINK: begin
            if ((state_q == S_BLK_ON) || (state_q == S_BLK_OFF)) begin
              if (fcnt_q == p_last) begin
                fcnt_q    <= 8'd0;
                state_q   <= (state_q == S_BLK_ON) ? S_BLK_OFF : S_BLK_ON;
                mask_en_q <= (state_q != S_BLK_ON);
              end else begin
                fcnt_q    <= fcnt_q + 8'd1;
                mask_en_q <= (state_q == S_BLK_ON);
              end
            end else begin
              state_q   <= S_BLK_ON;
              fcnt_q    <= 8'd0;
              mask_en_q <= 1'b1;
            end
          end
          MODE_PULSE: begin
            if (state_q == S_PULSE) begin
              // A go seen here is dropped: pulses are not queued
              if (fcnt_q == p_last) begin
                state_q   <= S_PDONE;
                fcnt_q    <= 8'd0;
                done_q    <= 1'b1;
                mask_en_q <= 1'b0;
              end else begin
                fcnt_q    <= fcnt_q + 8'd1;
                mask_en_q <= 1'b1;
              end
            end else if (go_pend_q) begin
              state_q   <= S_PULSE;
              fcnt_q    <= 8'd0;
              mask_en_q <= 1'b1;
            end else begin
              state_q   <= S_PDONE;
              fcnt_q    <= 8'd0;
              mask_en_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux returns pending copies; STATUS reports live sequencer state
  always_comb begin
    rd_data = 32'd0;
    case (sel)
      ADDR_CTRL:   rd_data = {30'd0, mode_p_q};
      ADDR_PERIOD: rd_data = {24'd0, period_p_q};
      ADDR_BORDER: rd_data = {20'd0, border_p_q};
      ADDR_WIN:    rd_data = {5'd0, win_hi_p_q, 5'd0, win_lo_p_q};
      ADDR_STATUS: rd_data = {21'd0, fcnt_q, done_q, phase, busy};
      default:     rd_data = 32'd0;
    endcase
  end

  assign mask_en    = mask_en_q;
  assign border_rgb = border_rgb_q;
  assign win_lo     = win_lo_q;
  assign win_hi     = win_hi_q;

endmodule

// File: tb/tb_disp_mask_ctrl.sv
// Directed bench for disp_mask_ctrl using a small 4x3-pixel frame with
// 4 clk per pixel (48 clk per frame).
module tb_disp_mask_ctrl;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int SUB = 4;
  localparam int FRAME_CLK = W * H * SUB;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [10:0] y;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        mask_en;
  logic [11:0] border_rgb;
  logic [10:0] win_lo;
  logic [10:0] win_hi;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int sub_c = 0;
  int px    = 0;
  int py    = 0;

  disp_mask_ctrl #(.H_ACTIVE(640)) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .cs         (cs),
    .write      (write),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .mask_en    (mask_en),
    .border_rgb (border_rgb),
    .win_lo     (win_lo),
    .win_hi     (win_hi),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic bit at_start();
    return (sub_c == 0) && (px == 0) && (py == 0);
  endfunction

  // One clk: after the edge, advance the pixel counter and let it settle
  task automatic step();
    @(posedge clk);
    #1;
    sub_c++;
    if (sub_c == SUB) begin
      sub_c = 0;
      px++;
      if (px == W) begin
        px = 0;
        py++;
        if (py == H) py = 0;
      end
    end
    x = 11'(px);
    y = 11'(py);
    #1;
  endtask

  // Advance until the current cycle is the frame-start (tick) cycle
  task automatic to_next_tick();
    step();
    for (int i = 0; i < 2 * FRAME_CLK && !at_start(); i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr    = {11'd0, a};
    wr_data = d;
    cs      = 1'b1;
    write   = 1'b1;
    step();
    cs      = 1'b0;
    write   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = {11'd0, a};
    #1;
    d = rd_data;
  endtask

  logic [31:0] r;
  int          ticks;
  int          bad;
  logic [5:0]  blink_mask  = 6'b110011;
  logic [31:0] blink_stat [6] = '{32'd2, 32'd10, 32'd0, 32'd8, 32'd2, 32'd10};
  logic [5:0]  pulse_mask  = 6'b000111;
  logic [31:0] pulse_stat [6] = '{32'd1, 32'd9, 32'd17, 32'd4, 32'd4, 32'd4};
  logic [4:0]  fast_mask   = 5'b10101;
  logic [31:0] fast_stat [5] = '{32'd6, 32'd4, 32'd6, 32'd4, 32'd6};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; x = 11'd0; y = 11'd0;
    cs = 1'b0; write = 1'b0; addr = 14'd0; wr_data = 32'd0;
    repeat (3) @(posedge clk);
    #3;
    check("rst mask_en", {31'd0, mask_en}, 32'd0);
    check("rst border_rgb", {20'd0, border_rgb}, 32'h0fff);
    check("rst win_lo", {21'd0, win_lo}, 32'd0);
    check("rst win_hi", {21'd0, win_hi}, 32'd639);
    reset = 1'b1;
    #1;
    check("no tick at release on origin", {31'd0, frame_tick}, 32'd0);
    rd(3'd0, r); check("rst CTRL", r, 32'd0);
    rd(3'd1, r); check("rst PERIOD", r, 32'd1);
    rd(3'd3, r); check("rst WIN", r, 32'h027f_0000);
    rd(3'd4, r); check("rst STATUS", r, 32'd0);
    rd(3'd5, r); check("unmapped read", r, 32'd0);

    // Three frames: tick exactly on each frame start, never on hold cycles
    ticks = 0; bad = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      step();
      if (frame_tick) ticks++;
      if (frame_tick !== at_start()) bad++;
    end
    check("tick count 3 frames", ticks, 32'd3);
    check("tick placement errors", bad, 32'd0);
    check("idle mask_en", {31'd0, mask_en}, 32'd0);
    check("idle border_rgb", {20'd0, border_rgb}, 32'h0fff);
    check("idle win_hi", {21'd0, win_hi}, 32'd639);

    // Mid-frame BORDER write: visible on read next clk, committed at next frame
    to_next_tick();
    repeat (5) step();
    wr(3'd2, 32'h0000_00f0);
    check("BORDER readback", rd_data, 32'h0f0);
    check("border before tick", {20'd0, border_rgb}, 32'h0fff);
    to_next_tick();
    check("border in tick cycle", {20'd0, border_rgb}, 32'h0fff);
    step();
    check("border after tick", {20'd0, border_rgb}, 32'h00f0);

    // Write coincident with the tick waits one more frame
    to_next_tick();
    check("frame_tick high", {31'd0, frame_tick}, 32'd1);
    wr(3'd2, 32'h0000_000f);
    check("border coincident", {20'd0, border_rgb}, 32'h00f0);
    check("BORDER pending", rd_data, 32'h00f);
    to_next_tick();
    step();
    check("border next frame", {20'd0, border_rgb}, 32'h000f);

    // Window bounds
    wr(3'd3, 32'h0258_0028);
    check("WIN readback", rd_data, 32'h0258_0028);
    to_next_tick();
    step();
    check("win_lo commit", {21'd0, win_lo}, 32'd40);
    check("win_hi commit", {21'd0, win_hi}, 32'd600);

    // Blink, half-period 2 frames
    wr(3'd1, 32'd2);
    wr(3'd0, 32'd2);
    for (int k = 0; k < 6; k++) begin
      to_next_tick();
      step();
      check($sformatf("blink mask f%0d", k), {31'd0, mask_en}, {31'd0, blink_mask[k]});
      rd(3'd4, r);
      check($sformatf("blink status f%0d", k), r, blink_stat[k]);
    end

    // Pulse of 3 frames; second go mid-pulse must be dropped
    wr(3'd1, 32'd3);
    wr(3'd0, 32'd7);
    rd(3'd0, r); check("CTRL go not stored", r, 32'd3);
    for (int k = 0; k < 6; k++) begin
      to_next_tick();
      step();
      check($sformatf("pulse mask f%0d", k), {31'd0, mask_en}, {31'd0, pulse_mask[k]});
      rd(3'd4, r);
      check($sformatf("pulse status f%0d", k), r, pulse_stat[k]);
      if (k == 1) wr(3'd0, 32'd7);
    end

    // Period 0 behaves as 1: toggle every frame
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd2);
    rd(3'd1, r); check("PERIOD 0 readback", r, 32'd0);
    for (int k = 0; k < 5; k++) begin
      to_next_tick();
      step();
      check($sformatf("fast blink mask f%0d", k), {31'd0, mask_en}, {31'd0, fast_mask[k]});
      rd(3'd4, r);
      check($sformatf("fast blink status f%0d", k), r, fast_stat[k]);
    end

    // Asynchronous reset mid-frame while the mask is on
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    check("async rst mask_en", {31'd0, mask_en}, 32'd0);
    check("async rst border_rgb", {20'd0, border_rgb}, 32'h0fff);
    check("async rst win_lo", {21'd0, win_lo}, 32'd0);
    check("async rst win_hi", {21'd0, win_hi}, 32'd639);
    rd(3'd4, r); check("async rst STATUS", r, 32'd0);
    rd(3'd0, r); check("async rst CTRL", r, 32'd0);
    rd(3'd1, r); check("async rst PERIOD", r, 32'd1);
    rd(3'd2, r); check("async rst BORDER", r, 32'h0fff);
    rd(3'd3, r); check("async rst WIN", r, 32'h027f_0000);
    reset = 1'b1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
